alu_cmd_ctrl: RTL and testbench

Command front-end that drives the ALU. It assembles operand and function bytes arriving from the UART receiver, issues a single-cycle ALU enable, and captures the 16-bit result. It then returns the result to the UART transmitter as two bytes, low byte first. It sits between UART RX/TX and the ALU and plays the initiator role toward the ALU.

---
 rtl/alu_cmd_ctrl_if.sv | 33 +++
 rtl/alu_cmd_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// Bundle of the UART-facing and ALU-facing signals around the ALU command front-end.
// Latency: none; this is wiring only.
// Backpressure: TX_BUSY from the transmitter; the RX side has no backpressure (bytes are pulses).
// Ports: RX_P_DATA/RX_D_VLD (UART RX), ALU_A/ALU_B/ALU_FUN/ALU_EN -> ALU,
//        ALU_OUT/ALU_OUT_VLD <- ALU, TX_P_DATA/TX_D_VLD -> UART TX, TX_BUSY <- UART TX.
// Modports: master = command controller side, slave = surrounding UART/ALU side.
interface alu_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int FUN_W  = 4,
  parameter int OUT_W  = 16
);
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_VLD;
  logic [OUT_W-1:0]  ALU_OUT;
  logic              ALU_OUT_VLD;
  logic              TX_BUSY;
  logic [DATA_W-1:0] ALU_A;
  logic [DATA_W-1:0] ALU_B;
  logic [FUN_W-1:0]  ALU_FUN;
  logic              ALU_EN;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Purpose: assembles CC,A,B,FUN commands from UART RX bytes, fires the ALU, returns the result low byte first.
// Latency: ALU_EN one cycle after the FUN byte; first TX_D_VLD three cycles after ALU_EN when TX is idle.
// Backpressure: each TX byte waits for TX_BUSY=0, then waits out a full busy rise/fall before moving on.
// Ports: CLK, RST (async active-high); bus (alu_cmd_ctrl_if.master) carries RX byte in,
//        ALU operands/enable out, ALU result in, TX byte/request out, TX_BUSY in.
// Build option: define ALU_OPERAND_REUSE_EN to accept CMD_FUN (DD,FUN) reusing the stored A/B.
module alu_cmd_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                FUN_W    = 4,
  parameter int                OUT_W    = 16,
  parameter logic [DATA_W-1:0] CMD_OP   = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_FUN  = 8'hDD,
  parameter logic [DATA_W-1:0] ERR_BYTE = 8'hEE,
  parameter logic [FUN_W-1:0]  MAX_FUN  = 4'd13
) (
  input  logic            CLK,
  input  logic            RST,
  alu_cmd_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ISSUE, CAPTURE,
    TX_LO, TX_LO_WAIT, TX_HI, TX_HI_WAIT, TX_ERR, TX_ERR_WAIT
  } state_t;

  state_t             state;
  logic [OUT_W-1:0]   result;
  // Set once the transmitter has acknowledged our byte by raising TX_BUSY.
  logic               seen_busy;

  logic               fun_bad;
  assign fun_bad = (bus.RX_P_DATA[DATA_W-1:FUN_W] != '0) ||
                   (bus.RX_P_DATA[FUN_W-1:0] > MAX_FUN);

`ifndef ALU_OPERAND_REUSE_EN
  // The function-only opcode has no meaning in this build.
  logic unused_cmd_fun;
  assign unused_cmd_fun = ^CMD_FUN;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      result        <= '0;
      seen_busy     <= 1'b0;
      bus.ALU_A     <= '0;
      bus.ALU_B     <= '0;
      bus.ALU_FUN   <= '0;
      bus.ALU_EN    <= 1'b0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD  <= 1'b0;
    end else begin
      // Pulsed outputs default low so they last exactly one cycle.
      bus.ALU_EN   <= 1'b0;
      bus.TX_D_VLD <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.RX_D_VLD) begin
            if (bus.RX_P_DATA == CMD_OP) begin
              state <= GET_A;
            end
`ifdef ALU_OPERAND_REUSE_EN
            else if (bus.RX_P_DATA == CMD_FUN) begin
              state <= GET_FUN;
            end
`endif
          end
        end

        GET_A: begin
          if (bus.RX_D_VLD) begin
            bus.ALU_A <= bus.RX_P_DATA;
            state     <= GET_B;
          end
        end

        GET_B: begin
          if (bus.RX_D_VLD) begin
            bus.ALU_B <= bus.RX_P_DATA;
            state     <= GET_FUN;
          end
        end

        GET_FUN: begin
          if (bus.RX_D_VLD) begin
            bus.ALU_FUN <= bus.RX_P_DATA[FUN_W-1:0];
            if (fun_bad) begin
              state <= TX_ERR;
            end else begin
              // Raised here so the registered enable is high during ISSUE.
              bus.ALU_EN <= 1'b1;
              state      <= ISSUE;
            end
          end
        end

        ISSUE: begin
          state <= CAPTURE;
        end

        CAPTURE: begin
          // ALU registered its result at the end of ISSUE.
          if (bus.ALU_OUT_VLD) begin
            result <= bus.ALU_OUT;
            state  <= TX_LO;
          end else begin
            state <= TX_ERR;
          end
        end

        TX_LO: begin
          if (!bus.TX_BUSY) begin
            bus.TX_P_DATA <= result[DATA_W-1:0];
            bus.TX_D_VLD  <= 1'b1;
            seen_busy     <= 1'b0;
            state         <= TX_LO_WAIT;
          end
        end

        TX_HI: begin
          if (!bus.TX_BUSY) begin
            bus.TX_P_DATA <= result[OUT_W-1 -: DATA_W];
            bus.TX_D_VLD  <= 1'b1;
            seen_busy     <= 1'b0;
            state         <= TX_HI_WAIT;
          end
        end

        TX_ERR: begin
          if (!bus.TX_BUSY) begin
            bus.TX_P_DATA <= ERR_BYTE;
            bus.TX_D_VLD  <= 1'b1;
            seen_busy     <= 1'b0;
            state         <= TX_ERR_WAIT;
          end
        end

        TX_LO_WAIT, TX_HI_WAIT, TX_ERR_WAIT: begin
          if (bus.TX_BUSY) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            state <= (state == TX_LO_WAIT) ? TX_HI : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: ALU and UART TX are small behavioural models,
// each step drives RX bytes and checks ALU_EN captures and the transmitted bytes.
module tb_alu_cmd_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if bus ();
  alu_cmd_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;

  // ALU model knobs
  logic [15:0] alu_resp = 16'h0;
  logic        alu_ok   = 1'b1;
  // TX model
  logic ext_busy = 1'b0;
  logic mdl_busy = 1'b0;
  int   busy_cnt = 0;
  assign bus.TX_BUSY = mdl_busy | ext_busy;

  // Registered ALU: result visible the cycle after ALU_EN.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.ALU_OUT     <= 16'h0;
      bus.ALU_OUT_VLD <= 1'b0;
    end else if (bus.ALU_EN) begin
      bus.ALU_OUT     <= alu_resp;
      bus.ALU_OUT_VLD <= alu_ok;
    end
  end

  // Monitor and transmitter model, on the falling edge.
  int         cyc = 0;
  int         rx_cyc = 0;
  int         en_cnt = 0;
  int         en_cyc = 0;
  logic [7:0] en_a = 8'h0, en_b = 8'h0;
  logic [3:0] en_fun = 4'h0;
  int         viol = 0;
  int         consec = 0;
  logic       prev_vld = 1'b0;
  logic [7:0] txq[$];
  int         tx_cyc[$];

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (bus.RX_D_VLD) rx_cyc <= cyc;
    if (bus.ALU_EN) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
      en_a   <= bus.ALU_A;
      en_b   <= bus.ALU_B;
      en_fun <= bus.ALU_FUN;
    end
    if (bus.TX_D_VLD) begin
      if (bus.TX_BUSY) viol <= viol + 1;
      if (prev_vld) consec <= consec + 1;
      txq.push_back(bus.TX_P_DATA);
      tx_cyc.push_back(cyc);
      mdl_busy <= 1'b1;
      busy_cnt <= 5;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      mdl_busy <= (busy_cnt > 1);
    end
    prev_vld <= bus.TX_D_VLD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int base, en0, rel_cyc;

  initial begin
    bus.RX_P_DATA = 8'h0;
    bus.RX_D_VLD  = 1'b0;

    // Reset state
    idle(3);
    chk("rst_alu_a",   {24'h0, bus.ALU_A},     32'h0);
    chk("rst_alu_b",   {24'h0, bus.ALU_B},     32'h0);
    chk("rst_alu_fun", {28'h0, bus.ALU_FUN},   32'h0);
    chk("rst_alu_en",  {31'h0, bus.ALU_EN},    32'h0);
    chk("rst_tx_data", {24'h0, bus.TX_P_DATA}, 32'h0);
    chk("rst_tx_vld",  {31'h0, bus.TX_D_VLD},  32'h0);
    RST = 1'b0;
    idle(2);

    // 1: CC,05,03,00 -> 0x0008
    base = txq.size(); en0 = en_cnt; alu_resp = 16'h0008;
    send_cmd(8'h05, 8'h03, 8'h00);
    idle(40);
    chk("s1_en_cnt", en_cnt - en0, 1);
    chk("s1_a",   {24'h0, en_a},   32'h05);
    chk("s1_b",   {24'h0, en_b},   32'h03);
    chk("s1_fun", {28'h0, en_fun}, 32'h0);
    chk("s1_en_latency", en_cyc - rx_cyc, 1);
    chk("s1_tx_cnt", txq.size() - base, 2);
    chk("s1_tx_lo", {24'h0, txq[base]},   32'h08);
    chk("s1_tx_hi", {24'h0, txq[base+1]}, 32'h00);
    chk("s1_first_tx_ge2", {31'h0, (tx_cyc[base] - en_cyc) >= 2}, 32'h1);

    // DD,01 with operand reuse -> 0x0002
    base = txq.size(); en0 = en_cnt; alu_resp = 16'h0002;
    send_byte(8'hDD);
    send_byte(8'h01);
    idle(40);
`ifdef ALU_OPERAND_REUSE_EN
    chk("reuse_en_cnt", en_cnt - en0, 1);
    chk("reuse_a",   {24'h0, en_a},   32'h05);
    chk("reuse_b",   {24'h0, en_b},   32'h03);
    chk("reuse_fun", {28'h0, en_fun}, 32'h1);
    chk("reuse_tx_cnt", txq.size() - base, 2);
    chk("reuse_tx_lo", {24'h0, txq[base]},   32'h02);
    chk("reuse_tx_hi", {24'h0, txq[base+1]}, 32'h00);
`else
    chk("noreuse_en_cnt", en_cnt - en0, 0);
    chk("noreuse_tx_cnt", txq.size() - base, 0);
`endif

    // 2: CC,FF,FF,02 -> 0xFE01 with transmitter held busy at first
    base = txq.size(); en0 = en_cnt; alu_resp = 16'hFE01;
    ext_busy = 1'b1;
    send_cmd(8'hFF, 8'hFF, 8'h02);
    idle(10);
    chk("s2_held_tx_cnt", txq.size() - base, 0);
    rel_cyc = cyc;
    ext_busy = 1'b0;
    idle(40);
    chk("s2_en_cnt", en_cnt - en0, 1);
    chk("s2_tx_cnt", txq.size() - base, 2);
    chk("s2_tx_lo", {24'h0, txq[base]},   32'h01);
    chk("s2_tx_hi", {24'h0, txq[base+1]}, 32'hFE);
    chk("s2_after_release", {31'h0, tx_cyc[base] >= rel_cyc}, 32'h1);
    chk("s2_busy_waited", {31'h0, (tx_cyc[base+1] - tx_cyc[base]) >= 7}, 32'h1);
    chk("tx_vld_while_busy", viol, 0);
    chk("tx_vld_consecutive", consec, 0);

    // 3: illegal function 0x0E -> EE, no ALU_EN
    base = txq.size(); en0 = en_cnt;
    send_cmd(8'h01, 8'h02, 8'h0E);
    idle(30);
    chk("s3_en_cnt", en_cnt - en0, 0);
    chk("s3_tx_cnt", txq.size() - base, 1);
    chk("s3_tx_err", {24'h0, txq[base]}, 32'hEE);

    // Upper bits set in FUN byte -> EE
    base = txq.size(); en0 = en_cnt;
    send_cmd(8'h01, 8'h02, 8'h10);
    idle(30);
    chk("upper_en_cnt", en_cnt - en0, 0);
    chk("upper_tx_err", {24'h0, txq[base]}, 32'hEE);
    chk("upper_tx_cnt", txq.size() - base, 1);

    // Highest legal code 0x0D executes
    base = txq.size(); en0 = en_cnt; alu_resp = 16'hAB0D;
    send_cmd(8'h11, 8'h22, 8'h0D);
    idle(40);
    chk("max_en_cnt", en_cnt - en0, 1);
    chk("max_fun", {28'h0, en_fun}, 32'hD);
    chk("max_tx_lo", {24'h0, txq[base]},   32'h0D);
    chk("max_tx_hi", {24'h0, txq[base+1]}, 32'hAB);

    // ALU result not valid in CAPTURE -> EE
    base = txq.size(); en0 = en_cnt; alu_ok = 1'b0;
    send_cmd(8'h01, 8'h01, 8'h00);
    idle(30);
    alu_ok = 1'b1;
    chk("novld_en_cnt", en_cnt - en0, 1);
    chk("novld_tx_cnt", txq.size() - base, 1);
    chk("novld_tx_err", {24'h0, txq[base]}, 32'hEE);

    // 5: junk 0x55 then CC,07,01,04 -> 0x0001
    base = txq.size(); en0 = en_cnt; alu_resp = 16'h0001;
    send_byte(8'h55);
    send_cmd(8'h07, 8'h01, 8'h04);
    idle(40);
    chk("s5_en_cnt", en_cnt - en0, 1);
    chk("s5_a",   {24'h0, en_a},   32'h07);
    chk("s5_b",   {24'h0, en_b},   32'h01);
    chk("s5_fun", {28'h0, en_fun}, 32'h4);
    chk("s5_tx_lo", {24'h0, txq[base]},   32'h01);
    chk("s5_tx_hi", {24'h0, txq[base+1]}, 32'h00);

    // 6: reset between low and high bytes
    base = txq.size(); alu_resp = 16'h1234;
    send_cmd(8'h02, 8'h02, 8'h03);
    for (int i = 0; i < 60 && txq.size() == base; i++) idle(1);
    chk("s6_lo_sent", txq.size() - base, 1);
    chk("s6_tx_lo", {24'h0, txq[base]}, 32'h34);
    idle(2);
    #2 RST = 1'b1;
    #1;
    chk("s6_rst_alu_a",   {24'h0, bus.ALU_A},     32'h0);
    chk("s6_rst_alu_b",   {24'h0, bus.ALU_B},     32'h0);
    chk("s6_rst_alu_fun", {28'h0, bus.ALU_FUN},   32'h0);
    chk("s6_rst_tx_data", {24'h0, bus.TX_P_DATA}, 32'h0);
    chk("s6_rst_tx_vld",  {31'h0, bus.TX_D_VLD},  32'h0);
    idle(2);
    RST = 1'b0;
    idle(40);
    chk("s6_no_hi_byte", txq.size() - base, 1);

    base = txq.size(); en0 = en_cnt; alu_resp = 16'h0007;
    send_cmd(8'h03, 8'h04, 8'h00);
    idle(40);
    chk("s6_next_en_cnt", en_cnt - en0, 1);
    chk("s6_next_a", {24'h0, en_a}, 32'h03);
    chk("s6_next_b", {24'h0, en_b}, 32'h04);
    chk("s6_next_tx_cnt", txq.size() - base, 2);
    chk("s6_next_tx_lo", {24'h0, txq[base]},   32'h07);
    chk("s6_next_tx_hi", {24'h0, txq[base+1]}, 32'h00);
    chk("final_vld_while_busy", viol, 0);
    chk("final_vld_consecutive", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
